fifo_rd_port: RTL and testbench
===============================

# fifo_rd_port

Read-side controller of the synchronous FIFO memory. It sits between the FIFO storage array and the downstream consumer. It owns the read pointer and issues addresses to the 1-cycle-latency memory. It returns words through a valid/ready output register, and derives occupancy from the writer's pointer using the team's n-bit adder-style modular arithmetic.

## Interface
- `bits`, 4, address width; FIFO depth = 2**bits; pointers are bits+1 wide.
- `width`, 8, data word width.
- `AE_LEVEL`, 2, almost-empty threshold; used only when the macro is defined.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_ptr`  in  bits+1  writer's binary pointer, same clock domain.
- `rd_ptr`  out  bits+1  read pointer, returned to the writer for its full flag.
- `mem_re`  out  1  memory read strobe.
- `mem_addr`  out  bits  memory read address, equal to `rd_ptr[bits-1:0]`.
- `mem_data`  in  width  memory read data, valid the cycle after `mem_re`.
- `dout`  out  width  output word.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  consumer accepts `dout`.
- `empty`  out  1  no word anywhere in the reader or memory.
- `count`  out  bits+1  unfetched words = `(wr_ptr - rd_ptr) mod 2**(bits+1)`.
- `almost_empty`  out  1  present only when `FIFO_RD_ALMOST_EMPTY_EN` is defined.

## Operation
- FSM states:
  - IDLE: output register empty, no read in flight.
  - FETCH: read in flight.
  - VALID: `dout_valid`=1.
- Transitions:
  - IDLE: `count`>0 → FETCH, with `mem_re`=1 this cycle. Otherwise stay.
  - FETCH: unconditionally → VALID; `dout <= mem_data`.
  - VALID, `dout_ready`=0: stay; `dout` is held stable.
  - VALID, `dout_ready`=1, `count`>0: → FETCH, with `mem_re`=1 this cycle.
  - VALID, `dout_ready`=1, `count`=0: → IDLE.
- `rd_ptr` increments by 1 on every edge where `mem_re`=1. It wraps from 2**(bits+1)-1 to 0, and the carry out is discarded.
- `mem_re` and `mem_addr` are combinational from state, `count` and `dout_ready`. They never assert in FETCH.
- `count` is combinational modular subtraction, with no saturation. `count` > 2**bits is a writer protocol error, and the block does not detect it.
- `empty` = (`count`==0) and (state==IDLE).
- Reset values: `rd_ptr`=0, `dout`=0, `dout_valid`=0, state IDLE, `mem_re`=0. `count` and `empty` follow from `wr_ptr` (the writer resets to 0 in the same cycle, giving `count`=0 and `empty`=1).

## Timing
- Read latency: `mem_re` in cycle N, FETCH in N+1, `dout_valid` in N+2.
- Throughput: one word per 2 cycles under continuous `dout_ready`. `dout_valid` drops for exactly one cycle between words.
- Handshake: a transfer occurs on an edge where `dout_valid` and `dout_ready` are both 1. `dout` must not change while `dout_valid`=1 and `dout_ready`=0.
- A `wr_ptr` change is visible in `count` in the same cycle. A word written in cycle N can be fetched in cycle N.
- `rst` asserted in any state wins over all other events on that edge. An in-flight read is discarded, and `mem_data` from it is ignored.
- Simultaneous consume and new data: VALID with `dout_ready`=1 while `wr_ptr` rises from equal to `rd_ptr` takes the `count`>0 branch in the same cycle.

## Configuration
- `FIFO_RD_ALMOST_EMPTY_EN` defined:
  - Adds the `almost_empty` port.
  - `almost_empty` = (`count` <= `AE_LEVEL`), combinational.
  - `almost_empty` is 1 out of reset.
- Undefined: no `almost_empty` port; `AE_LEVEL` is ignored; all other behaviour is identical.

## Test plan
All scenarios use bits=4, width=8.
- **Reset**: `rst`=1 for 2 cycles with `wr_ptr`=0 → `rd_ptr`=0, `dout`=0, `dout_valid`=0, `empty`=1, `count`=0, `mem_re`=0.
- **Single word**:
  - Stimulus: `wr_ptr`=1, memory returns 8'hA5, `dout_ready`=1.
  - Response: `mem_re`=1 with `mem_addr`=0 in cycle 0; `dout_valid`=1 with `dout`=8'hA5 in cycle 2; IDLE and `empty`=1 in cycle 3; `rd_ptr`=1.
- **Backpressure**:
  - Stimulus: `wr_ptr`=3, `dout_ready`=0 for 10 cycles, then `dout_ready`=1.
  - While stalled: exactly one `mem_re`, `rd_ptr`=1, `dout` constant, `count`=2.
  - After release: words 2 and 3 appear 2 cycles apart; `rd_ptr`=3.
- **Wrap**:
  - Stimulus: step `rd_ptr` to 30, then set `wr_ptr`=2, giving `count`=4.
  - Response: `mem_addr` sequence is 14, 15, 0, 1; final `rd_ptr`=2 and `count`=0.
- **Reset mid-FETCH**: `rst`=1 in the FETCH cycle → next cycle `dout_valid`=0, `dout`=0, `rd_ptr`=0; the fetched word never appears.
- **Almost-empty** (macro defined, AE_LEVEL=2): `count` stepping 4→3→2 → `almost_empty` is 0, 0, then 1. Without the macro the port is absent and the other outputs match bit-for-bit.

Source files
------------

// File: rtl/fifo_rd_port.sv
// Read side of the synchronous FIFO: owns rd_ptr, fetches from 1-cycle memory, presents words on a valid/ready register.
// Optional almost_empty output is enabled by defining FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_port #(
  parameter int bits     = 4,
  parameter int width    = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [bits:0]    wr_ptr,
  output logic [bits:0]    rd_ptr,
  output logic             mem_re,
  output logic [bits-1:0]  mem_addr,
  input  logic [width-1:0] mem_data,
  output logic [width-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             empty,
  output logic [bits:0]    count
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic             almost_empty
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0] state;
  logic       have_data;

  // Modular difference; the pointer MSB disambiguates full from empty.
  assign count     = wr_ptr - rd_ptr;
  assign have_data = (count != '0);
  assign mem_addr  = rd_ptr[bits-1:0];

  // A read is issued whenever the output register is, or is about to be, free.
  always_comb begin
    mem_re = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    mem_re = have_data;
        VALID:   mem_re = dout_ready && have_data;
        default: mem_re = 1'b0;
      endcase
    end
  end

  assign dout_valid = (state == VALID);
  assign empty      = !have_data && (state == IDLE);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [bits:0] AE_THR = AE_LEVEL[bits:0];
  assign almost_empty = (count <= AE_THR);
`else
  logic unused_ae;
  assign unused_ae = ^AE_LEVEL;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (mem_re) begin
        rd_ptr <= rd_ptr + (bits+1)'(1);
      end
      case (state)
        IDLE: begin
          if (mem_re) state <= FETCH;
        end
        FETCH: begin
          dout  <= mem_data;
          state <= VALID;
        end
        VALID: begin
          if (dout_ready) state <= mem_re ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port: per-cycle vector table plus hand-written wrap, reset-in-fetch and almost-empty sequences.
module tb_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr;
  logic       mem_re;
  logic [3:0] mem_addr;
  logic [7:0] mem_data = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       empty;
  logic [4:0] count;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  always #5 clk = ~clk;

  fifo_rd_port #(.bits(4), .width(8), .AE_LEVEL(2)) dut (
    .clk(clk),
    .rst(rst),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .mem_re(mem_re),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .empty(empty),
    .count(count)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .almost_empty(almost_empty)
`endif
  );

  // Storage array model with one cycle of read latency.
  logic [7:0] mem [16];
  always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr];

  typedef struct {
    logic       rst;
    logic [4:0] wr;
    logic       rdy;
    logic       re;
    logic [3:0] addr;
    logic       vld;
    logic [7:0] dout;
    logic [4:0] rd;
    logic [4:0] cnt;
    logic       emp;
    logic       chk;
  } vec_t;

  vec_t tv[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [4:0] w, input logic y, input logic re,
                     input logic [3:0] a, input logic v, input logic [7:0] d,
                     input logic [4:0] rp, input logic [4:0] c, input logic e);
    vec_t t;
    t = '{rst: r, wr: w, rdy: y, re: re, addr: a, vld: v, dout: d, rd: rp, cnt: c, emp: e, chk: 1'b1};
    tv.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_ptr = '0;
    dout_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] addrs[$];
    logic [3:0] exp_addr [4];
    bit         done;
    bit         seen;

    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    mem[0] = 8'hA5;
    mem[1] = 8'hB1;
    mem[2] = 8'hB2;

    // Columns: rst wr rdy | mem_re addr valid dout rd_ptr count empty (values seen before the edge).
    begin
      vec_t t0;
      t0 = '{rst: 1'b1, wr: 5'd0, rdy: 1'b1, re: 1'b0, addr: 4'd0, vld: 1'b0, dout: 8'h0,
             rd: 5'd0, cnt: 5'd0, emp: 1'b1, chk: 1'b0};
      tv.push_back(t0);
    end
    add(1, 0, 1,  0, 0, 0, 8'h00, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 8'h00, 0, 0, 1);
    // single word
    add(0, 1, 1,  1, 0, 0, 8'h00, 0, 1, 0);
    add(0, 1, 1,  0, 1, 0, 8'h00, 1, 0, 0);
    add(0, 1, 1,  0, 1, 1, 8'hA5, 1, 0, 0);
    add(0, 1, 1,  0, 1, 0, 8'hA5, 1, 0, 1);
    add(1, 1, 0,  0, 1, 0, 8'hA5, 1, 0, 1);
    add(0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 1);
    // backpressure: ready low for ten cycles
    add(0, 3, 0,  1, 0, 0, 8'h00, 0, 3, 0);
    add(0, 3, 0,  0, 1, 0, 8'h00, 1, 2, 0);
    for (int k = 0; k < 8; k++) add(0, 3, 0,  0, 1, 1, 8'hA5, 1, 2, 0);
    add(0, 3, 1,  1, 1, 1, 8'hA5, 1, 2, 0);
    add(0, 3, 1,  0, 2, 0, 8'hA5, 2, 1, 0);
    add(0, 3, 1,  1, 2, 1, 8'hB1, 2, 1, 0);
    add(0, 3, 1,  0, 3, 0, 8'hB1, 3, 0, 0);
    // consume while a new word lands in the same cycle
    add(0, 4, 1,  1, 3, 1, 8'hB2, 3, 1, 0);
    add(0, 4, 1,  0, 4, 0, 8'hB2, 4, 0, 0);
    add(0, 4, 1,  0, 4, 1, 8'h43, 4, 0, 0);
    add(0, 4, 1,  0, 4, 0, 8'h43, 4, 0, 1);

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst;
      wr_ptr = tv[i].wr;
      dout_ready = tv[i].rdy;
      #1;
      if (tv[i].chk) begin
        check($sformatf("row%0d mem_re", i), 32'(mem_re), 32'(tv[i].re));
        if (tv[i].re) check($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].addr));
        check($sformatf("row%0d dout_valid", i), 32'(dout_valid), 32'(tv[i].vld));
        check($sformatf("row%0d dout", i), 32'(dout), 32'(tv[i].dout));
        check($sformatf("row%0d rd_ptr", i), 32'(rd_ptr), 32'(tv[i].rd));
        check($sformatf("row%0d count", i), 32'(count), 32'(tv[i].cnt));
        check($sformatf("row%0d empty", i), 32'(empty), 32'(tv[i].emp));
      end
    end

    // Wrap: drain 30 words, then a writer wrap makes count 4 across the pointer boundary.
    do_reset();
    wr_ptr = 5'd30;
    dout_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      #1;
      if (rd_ptr == 5'd30 && empty) done = 1'b1;
    end
    check("wrap_prefill_rd_ptr", 32'(rd_ptr), 32'd30);
    @(negedge clk);
    wr_ptr = 5'd2;
    #1;
    check("wrap_count", 32'(count), 32'd4);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_re) addrs.push_back(mem_addr);
      if (empty) done = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    check("wrap_num_reads", 32'(addrs.size()), 32'd4);
    for (int k = 0; k < 4 && k < addrs.size(); k++)
      check($sformatf("wrap_addr%0d", k), 32'(addrs[k]), 32'(exp_addr[k]));
    check("wrap_final_rd_ptr", 32'(rd_ptr), 32'd2);
    check("wrap_final_count", 32'(count), 32'd0);
    check("wrap_last_dout", 32'(dout), 32'hB1);

    // Reset landing on the FETCH cycle discards the in-flight word.
    do_reset();
    wr_ptr = 5'd1;
    dout_ready = 1'b1;
    #1;
    check("rstfetch_issue", 32'(mem_re), 32'd1);
    @(negedge clk);
    #1;
    check("rstfetch_in_fetch", 32'(mem_re), 32'd0);
    rst = 1'b1;
    wr_ptr = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstfetch_valid", 32'(dout_valid), 32'd0);
    check("rstfetch_dout", 32'(dout), 32'd0);
    check("rstfetch_rd_ptr", 32'(rd_ptr), 32'd0);
    check("rstfetch_empty", 32'(empty), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (dout_valid) seen = 1'b1;
    end
    check("rstfetch_word_dropped", 32'(seen), 32'd0);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    do_reset();
    #1;
    check("ae_reset", 32'(almost_empty), 32'd1);
    wr_ptr = 5'd4;
    dout_ready = 1'b1;
    #1;
    check("ae_count4", 32'(almost_empty), 32'd0);
    @(negedge clk);
    #1;
    check("ae_count3_fetch", 32'(almost_empty), 32'd0);
    check("ae_count3_value", 32'(count), 32'd3);
    @(negedge clk);
    #1;
    check("ae_count3_valid", 32'(almost_empty), 32'd0);
    @(negedge clk);
    #1;
    check("ae_count2_value", 32'(count), 32'd2);
    check("ae_count2", 32'(almost_empty), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
